// File: rtl/exe_stage.sv
// EXE pipeline stage: single-cycle ADD/SUB/OR plus a 32-step iterative shift-add MUL.
// While a multiply iterates, stall holds upstream and the output register carries bubbles.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        wreg,
  input  logic        m2reg,
  input  logic        wmem,
  input  logic        aluimm,
  input  logic [1:0]  aluOp,
  input  logic [4:0]  rd,
  input  logic [31:0] qa,
  input  logic [31:0] qb,
  input  logic [31:0] imm,
  output logic        stall,
  output logic        ewreg_out,
  output logic        em2reg_out,
  output logic        ewmem_out,
  output logic [4:0]  erd_out,
  output logic [31:0] alu_out,
  output logic [31:0] store_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        lwreg_q, lwreg_d;
  logic        lm2reg_q, lm2reg_d;
  logic        lwmem_q, lwmem_d;
  logic [4:0]  lrd_q, lrd_d;
  logic [31:0] lstore_q, lstore_d;

  logic        ewreg_q, ewreg_d;
  logic        em2reg_q, em2reg_d;
  logic        ewmem_q, ewmem_d;
  logic [4:0]  erd_q, erd_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] store_q, store_d;

  logic [31:0] opB;
  logic [31:0] aluRes;

  always_comb begin
    opB = aluimm ? imm : qb;
    case (aluOp)
      2'b00:   aluRes = qa + opB;
      2'b01:   aluRes = qa - opB;
      2'b10:   aluRes = qa | opB;
      default: aluRes = 32'd0;
    endcase
  end

  // Output register defaults to a bubble; only a non-MUL in IDLE or the DONE cycle load real values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    lwreg_d  = lwreg_q;
    lm2reg_d = lm2reg_q;
    lwmem_d  = lwmem_q;
    lrd_d    = lrd_q;
    lstore_d = lstore_q;
    stall    = 1'b0;
    ewreg_d  = 1'b0;
    em2reg_d = 1'b0;
    ewmem_d  = 1'b0;
    erd_d    = 5'd0;
    alu_d    = 32'd0;
    store_d  = 32'd0;
    case (state_q)
      IDLE: begin
        if (aluOp == 2'b11) begin
          stall    = 1'b1;
          state_d  = BUSY;
          cnt_d    = 6'd0;
          acc_d    = 32'd0;
          mcand_d  = qa;
          mplier_d = opB;
          lwreg_d  = wreg;
          lm2reg_d = m2reg;
          lwmem_d  = wmem;
          lrd_d    = rd;
          lstore_d = qb;
        end else begin
          ewreg_d  = wreg;
          em2reg_d = m2reg;
          ewmem_d  = wmem;
          erd_d    = rd;
          alu_d    = aluRes;
          store_d  = qb;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE: begin
        ewreg_d  = lwreg_q;
        em2reg_d = lm2reg_q;
        ewmem_d  = lwmem_q;
        erd_d    = lrd_q;
        alu_d    = acc_q;
        store_d  = lstore_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      lwreg_q  <= 1'b0;
      lm2reg_q <= 1'b0;
      lwmem_q  <= 1'b0;
      lrd_q    <= 5'd0;
      lstore_q <= 32'd0;
      ewreg_q  <= 1'b0;
      em2reg_q <= 1'b0;
      ewmem_q  <= 1'b0;
      erd_q    <= 5'd0;
      alu_q    <= 32'd0;
      store_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      lwreg_q  <= lwreg_d;
      lm2reg_q <= lm2reg_d;
      lwmem_q  <= lwmem_d;
      lrd_q    <= lrd_d;
      lstore_q <= lstore_d;
      ewreg_q  <= ewreg_d;
      em2reg_q <= em2reg_d;
      ewmem_q  <= ewmem_d;
      erd_q    <= erd_d;
      alu_q    <= alu_d;
      store_q  <= store_d;
    end
  end

  assign ewreg_out  = ewreg_q;
  assign em2reg_out = em2reg_q;
  assign ewmem_out  = ewmem_q;
  assign erd_out    = erd_q;
  assign alu_out    = alu_q;
  assign store_out  = store_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table, hand-written MUL/reset sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wreg, m2reg, wmem, aluimm;
  logic [1:0]  aluOp;
  logic [4:0]  rd;
  logic [31:0] qa, qb, imm;
  logic        stall;
  logic        ewreg_out, em2reg_out, ewmem_out;
  logic [4:0]  erd_out;
  logic [31:0] alu_out, store_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        aluimm;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
    logic [31:0] expAlu;
  } vec_t;

  exe_stage dut (
    .clk(clk), .rst(rst),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm),
    .aluOp(aluOp), .rd(rd), .qa(qa), .qb(qb), .imm(imm),
    .stall(stall),
    .ewreg_out(ewreg_out), .em2reg_out(em2reg_out), .ewmem_out(ewmem_out),
    .erd_out(erd_out), .alu_out(alu_out), .store_out(store_out)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the selected operands, truncated to 32 bits.
  function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] wide;
    case (op)
      2'd0:    wide = {32'd0, a} + {32'd0, b};
      2'd1:    wide = {32'd0, a} - {32'd0, b};
      2'd2:    wide = {32'd0, a | b};
      default: wide = {32'd0, a} * {32'd0, b};
    endcase
    return wide[31:0];
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wreg = v.wreg; m2reg = v.m2reg; wmem = v.wmem; aluimm = v.aluimm;
    aluOp = v.op; rd = v.rd; qa = v.qa; qb = v.qb; imm = v.imm;
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v, input logic [31:0] expAlu);
    check32({name, ".alu"}, alu_out, expAlu);
    check32({name, ".store"}, store_out, v.qb);
    check32({name, ".ctrl"}, {29'd0, ewreg_out, em2reg_out, ewmem_out},
            {29'd0, v.wreg, v.m2reg, v.wmem});
    check32({name, ".rd"}, {27'd0, erd_out}, {27'd0, v.rd});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one op and checks it; a MUL is followed through its full 34-posedge schedule.
  task automatic runOp(input vec_t v, input logic [31:0] expAlu, input bit scramble);
    int stallCnt;
    bit bubbleBad;
    applyStimulus(v);
    if (v.op != 2'd3) begin
      check32({v.name, ".stall"}, {31'd0, stall}, 32'd0);
      tick();
      checkOutput(v.name, v, expAlu);
    end else begin
      stallCnt = 0;
      bubbleBad = 0;
      for (int c = 1; c <= 34; c++) begin
        if (c <= 33 && stall) stallCnt++;
        if (c == 34) check32({v.name, ".stallDone"}, {31'd0, stall}, 32'd0);
        tick();
        if (c <= 33 && ({ewreg_out, em2reg_out, ewmem_out} != 3'b0 || erd_out != 5'd0 ||
                        alu_out != 32'd0 || store_out != 32'd0))
          bubbleBad = 1;
        if (scramble && c >= 1 && c <= 32) begin
          qa = $urandom; qb = $urandom; imm = $urandom; rd = 5'($urandom);
          wreg = 1'($urandom); wmem = 1'($urandom); aluimm = 1'($urandom);
          #1;
        end
      end
      check32({v.name, ".stallCycles"}, stallCnt, 33);
      check32({v.name, ".bubbles"}, {31'd0, bubbleBad}, 32'd0);
      checkOutput(v.name, v, expAlu);
    end
  endtask

  function automatic vec_t mk(input string name, input logic w, input logic m, input logic s,
                              input logic ai, input logic [1:0] op, input logic [4:0] r,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                              input logic [31:0] e);
    vec_t v;
    v.name = name; v.wreg = w; v.m2reg = m; v.wmem = s; v.aluimm = ai; v.op = op;
    v.rd = r; v.qa = a; v.qb = b; v.imm = i; v.expAlu = e;
    return v;
  endfunction

  vec_t table_q[6];

  initial begin
    vec_t v;
    logic [31:0] expected;

    table_q[0] = mk("addImm", 1, 0, 0, 1, 2'd0, 5'd3, 32'd5, 32'd77, 32'hFFFF_FFFD, 32'd2);
    table_q[1] = mk("subWrap", 1, 0, 0, 0, 2'd1, 5'd4, 32'd0, 32'd1, 32'd9, 32'hFFFF_FFFF);
    table_q[2] = mk("orReg", 1, 0, 0, 0, 2'd2, 5'd5, 32'hF0, 32'h0F, 32'h100, 32'hFF);
    table_q[3] = mk("storeOp", 0, 0, 1, 1, 2'd0, 5'd0, 32'h100, 32'hABCD, 32'd8, 32'h108);
    table_q[4] = mk("addWrap", 1, 1, 0, 0, 2'd0, 5'd31, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    table_q[5] = mk("orImm", 1, 0, 0, 1, 2'd2, 5'd17, 32'h1234_0000, 32'd0, 32'h0000_5678,
                    32'h1234_5678);

    rst = 1'b1;
    applyStimulus(mk("idle", 0, 0, 0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0));
    tick();
    tick();
    check32("reset.alu", alu_out, 32'd0);
    check32("reset.store", store_out, 32'd0);
    check32("reset.ctrl", {24'd0, ewreg_out, em2reg_out, ewmem_out, erd_out}, 32'd0);
    rst = 1'b0;
    #1;
    check32("reset.stall", {31'd0, stall}, 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) runOp(table_q[i], table_q[i].expAlu, 0);

    $display("[TB] multiply sequences");
    runOp(mk("mul1234", 1, 0, 0, 0, 2'd3, 5'd7, 32'd1234, 32'd5678, 32'd0, 32'd0),
          32'd7006652, 0);
    runOp(mk("mulAllOnes", 1, 0, 0, 0, 2'd3, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0),
          32'h1, 0);
    runOp(mk("addAfterMul", 1, 0, 0, 1, 2'd0, 5'd2, 32'd1, 32'd0, 32'd1, 32'd0), 32'd2, 0);
    runOp(mk("mulZero", 1, 0, 0, 0, 2'd3, 5'd1, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0), 32'd0, 0);
    runOp(mk("mulImmZero", 1, 0, 0, 1, 2'd3, 5'd6, 32'hCAFE, 32'h55, 32'd0, 32'd0), 32'd0, 0);
    runOp(mk("mulScrambled", 1, 0, 1, 1, 2'd3, 5'd12, 32'd1000, 32'h77, 32'd3000, 32'd0),
          32'd3000000, 1);
    runOp(mk("mulBackToBack", 1, 0, 0, 0, 2'd3, 5'd13, 32'h10001, 32'h10001, 32'd0, 32'd0),
          32'h0002_0001, 0);

    $display("[TB] reset during multiply");
    applyStimulus(mk("mulAbort", 1, 0, 0, 0, 2'd3, 5'd8, 32'd99, 32'd99, 32'd0, 32'd0));
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v = mk("addAfterRst", 1, 0, 0, 0, 2'd0, 5'd10, 32'd7, 32'd8, 32'd0, 32'd0);
    applyStimulus(v);
    check32("rstMid.stall", {31'd0, stall}, 32'd0);
    check32("rstMid.alu", alu_out, 32'd0);
    check32("rstMid.ctrl", {24'd0, ewreg_out, em2reg_out, ewmem_out, erd_out}, 32'd0);
    tick();
    checkOutput("rstMid.add", v, 32'd15);
    repeat (40) tick();
    check32("rstMid.noLateMul", alu_out, 32'd15);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      v.name = "rand";
      v.op = (r == 7) ? 2'd3 : 2'(r % 3);
      v.wreg = 1'($urandom); v.m2reg = 1'($urandom); v.wmem = 1'($urandom);
      v.aluimm = 1'($urandom); v.rd = 5'($urandom);
      v.qa = $urandom; v.qb = $urandom; v.imm = $urandom;
      if (r == 6) v.qa = 32'hFFFF_FFFF;
      expected = refAlu(v.op, v.qa, v.aluimm ? v.imm : v.qb);
      runOp(v, expected, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
